// File: rtl/output_fifo.sv
// Wide result buffer that serializes enabled 32-bit lanes as {lane, data} beats.
// Optional overflow counter enabled by defining OUTPUT_FIFO_OVF_CNT_EN.
module output_fifo #(
    parameter int unsigned LANE_WIDTH     = 32,
    parameter int unsigned LANES          = 16,
    parameter int unsigned WORD_WIDTH     = 512,
    parameter int unsigned DATA_OUT_WIDTH = 36,
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned REG_ADDR       = 2
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic                      WR_EN,
    input  logic [WORD_WIDTH-1:0]     din,
    output logic                      full,
    input  logic                      reg_en,
    input  logic [REG_ADDR-1:0]       a_reg,
    input  logic [LANES-1:0]          reg_din,
    output logic [LANES-1:0]          lane_mask,
    output logic [DATA_OUT_WIDTH-1:0] dout,
    output logic                      dout_valid,
    input  logic                      RD_EN,
    output logic                      empty,
    output logic                      busy,
    output logic                      word_done,
    output logic [7:0]                ovf_cnt
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  lane_q, lane_d;
    logic [LANES-1:0]            act_mask_q, act_mask_d;
    logic [LANES-1:0]            lane_mask_q, lane_mask_d;
    logic [DATA_OUT_WIDTH-1:0]   dout_q, dout_d;
    logic                        dout_valid_q, dout_valid_d;
    logic                        word_done_q, word_done_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WORD_WIDTH-1:0]       mem_q [DEPTH];

    logic                        full_c, push_ok, pop, load;
    logic [WORD_WIDTH-1:0]       load_word;
    logic [LANES-1:0]            rem;

    function automatic logic [3:0] low_lane(input logic [LANES-1:0] m);
        low_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i]) low_lane = 4'(i);
        end
    endfunction

    function automatic logic [LANES-1:0] above(input logic [LANES-1:0] m, input logic [3:0] l);
        above = '0;
        for (int i = 0; i < LANES; i++) begin
            above[i] = m[i] && (4'(i) > l);
        end
    endfunction

    function automatic logic [LANE_WIDTH-1:0] pick(input logic [WORD_WIDTH-1:0] w, input logic [3:0] l);
        pick = '0;
        for (int i = 0; i < LANES; i++) begin
            if (l == 4'(i)) pick = w[i*LANE_WIDTH +: LANE_WIDTH];
        end
    endfunction

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign push_ok = WR_EN && !full_c;

    // Next-state: lane stepping, word pop and back-to-back word load
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        act_mask_d   = act_mask_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        word_done_d  = 1'b0;
        rd_ptr_d     = rd_ptr_q;
        pop          = 1'b0;
        load         = 1'b0;
        load_word    = '0;
        rem          = '0;
        wr_ptr_d     = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        lane_mask_d  = (reg_en && (a_reg == '0) && (reg_din != '0)) ? reg_din : lane_mask_q;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    load      = 1'b1;
                    load_word = mem_q[rd_ptr_q];
                end
            end
            SEND: begin
                rem = above(act_mask_q, lane_q);
                if (dout_valid_q && RD_EN) begin
                    if (rem != '0) begin
                        lane_d = low_lane(rem);
                        dout_d = {lane_d, pick(mem_q[rd_ptr_q], lane_d)};
                    end else begin
                        pop         = 1'b1;
                        word_done_d = 1'b1;
                        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                        if (count_q > CNT_W'(1)) begin
                            load      = 1'b1;
                            load_word = mem_q[rd_ptr_d];
                        end else if (push_ok) begin
                            // Buffer drains this cycle; the word arriving now goes straight out
                            load      = 1'b1;
                            load_word = din;
                        end else begin
                            state_d      = IDLE;
                            dout_valid_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            act_mask_d   = lane_mask_q;
            lane_d       = low_lane(lane_mask_q);
            dout_d       = {lane_d, pick(load_word, lane_d)};
            dout_valid_d = 1'b1;
            state_d      = SEND;
        end

        count_d = count_q;
        if (push_ok && !pop) count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            act_mask_q   <= '1;
            lane_mask_q  <= '1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            act_mask_q   <= act_mask_d;
            lane_mask_q  <= lane_mask_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            word_done_q  <= word_done_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset; pointers and count qualify it
    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

`ifdef OUTPUT_FIFO_OVF_CNT_EN
    logic [7:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (WR_EN && full_c && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) ovf_q <= 8'h00;
        else        ovf_q <= ovf_d;
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = 8'h00;
`endif

    assign full       = full_c;
    assign empty      = (count_q == '0) && (state_q == IDLE);
    assign busy       = (state_q == SEND);
    assign lane_mask  = lane_mask_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign word_done  = word_done_q;
endmodule

// File: tb/tb_output_fifo.sv
// Scoreboard bench for output_fifo: directed words queued as expected beats, checked by a monitor.
module tb_output_fifo;
    logic         CLK = 1'b0;
    logic         rst_n = 1'b0;
    logic         WR_EN = 1'b0;
    logic [511:0] din = '0;
    logic         full;
    logic         reg_en = 1'b0;
    logic [1:0]   a_reg = '0;
    logic [15:0]  reg_din = '0;
    logic [15:0]  lane_mask;
    logic [35:0]  dout;
    logic         dout_valid;
    logic         RD_EN = 1'b0;
    logic         empty, busy, word_done;
    logic [7:0]   ovf_cnt;

    typedef struct packed {
        logic [35:0] beat;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic exp_wd = 1'b0;

    output_fifo dut (
        .CLK(CLK), .rst_n(rst_n), .WR_EN(WR_EN), .din(din), .full(full),
        .reg_en(reg_en), .a_reg(a_reg), .reg_din(reg_din), .lane_mask(lane_mask),
        .dout(dout), .dout_valid(dout_valid), .RD_EN(RD_EN), .empty(empty),
        .busy(busy), .word_done(word_done), .ovf_cnt(ovf_cnt)
    );

    always #5 CLK = ~CLK;

    // Monitor: pop one expected beat per accepted beat; word_done follows a last beat
    always @(negedge CLK) begin
        exp_t e;
        if (!rst_n) begin
            exp_wd = 1'b0;
        end else begin
            if (word_done || exp_wd) begin
                vectors++;
                if (word_done !== exp_wd) begin
                    miscompares++;
                    $display("FAIL word_done: got %b want %b", word_done, exp_wd);
                end
            end
            exp_wd = 1'b0;
            if (dout_valid && RD_EN) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: got %h want none", dout);
                end else begin
                    e = q.pop_front();
                    if (dout !== e.beat) begin
                        miscompares++;
                        $display("FAIL beat: got %h want %h", dout, e.beat);
                    end
                    exp_wd = e.last;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [511:0] make_word(input logic [31:0] base);
        logic [511:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = base + 32'(k);
        return w;
    endfunction

    task automatic expect_word(input logic [511:0] w, input logic [15:0] m);
        int last = 0;
        exp_t e;
        for (int k = 0; k < 16; k++) if (m[k]) last = k;
        for (int k = 0; k < 16; k++) begin
            if (m[k]) begin
                e.beat = {4'(k), w[k*32 +: 32]};
                e.last = (k == last);
                q.push_back(e);
            end
        end
    endtask

    task automatic push(input logic [511:0] w);
        WR_EN = 1'b1;
        din   = w;
        tick();
        WR_EN = 1'b0;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
        reg_en  = 1'b1;
        a_reg   = a;
        reg_din = d;
        tick();
        reg_en  = 1'b0;
    endtask

    // Drain with RD_EN high; cycle count equals beat count only if there are no bubbles
    task automatic drain_timed(input string name, input int n);
        int cycles = 0;
        RD_EN = 1'b1;
        while (q.size() != 0 && cycles < 500) begin
            tick();
            cycles++;
        end
        check(name, 64'(cycles), 64'(n));
    endtask

    task automatic wait_lane(input logic [3:0] l);
        int t = 0;
        while (!(dout_valid && dout[35:32] == l) && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) check("wait_lane_timeout", 64'(t), 64'(0));
    endtask

    logic [511:0] wa, wb, wc, wd, we, wf, wg, w1, w2, w3, wh, wi;

    initial begin
        wa = make_word(32'hA000_0000); wb = make_word(32'hB000_0000);
        wc = make_word(32'hC000_0000); wd = make_word(32'hD000_0000);
        we = make_word(32'hE000_0000); wf = make_word(32'hF000_0000);
        wg = make_word(32'h1000_0000); w1 = make_word(32'h2000_0000);
        w2 = make_word(32'h3000_0000); w3 = make_word(32'h4000_0000);
        wh = make_word(32'h5000_0000); wi = make_word(32'h6000_0000);

        #12;
        check("rst_lane_mask", 64'(lane_mask), 64'h FFFF);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_ovf", 64'(ovf_cnt), 64'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        tick();

        // Full word, RD_EN held high, one-cycle latency
        RD_EN = 1'b1;
        expect_word(wa, 16'hFFFF);
        push(wa);
        check("lat_e0_valid", 64'(dout_valid), 64'd0);
        tick();
        check("lat_e1_valid", 64'(dout_valid), 64'd1);
        check("lat_e1_dout", 64'(dout), 64'h0_A000_0000);
        drain_timed("drain_a_cycles", 16);
        check("empty_after_a", 64'(empty), 64'd1);

        // Sparse mask and ignored register writes
        reg_write(2'd0, 16'h8001);
        check("mask_8001", 64'(lane_mask), 64'h8001);
        expect_word(wb, 16'h8001);
        push(wb);
        drain_timed("drain_b_cycles", 3);
        reg_write(2'd0, 16'h0000);
        check("mask_zero_ignored", 64'(lane_mask), 64'h8001);
        reg_write(2'd1, 16'h1234);
        check("mask_addr_ignored", 64'(lane_mask), 64'h8001);

        // Mask change while a word is in flight only affects the next word
        RD_EN = 1'b0;
        expect_word(wc, 16'h8001);
        push(wc);
        expect_word(wd, 16'h00FF);
        push(wd);
        reg_write(2'd0, 16'h00FF);
        check("inflight_dout", 64'(dout), {28'd0, 4'h0, wc[31:0]});
        drain_timed("drain_cd_cycles", 10);

        // Back-pressure freezes the current beat
        reg_write(2'd0, 16'hFFFF);
        RD_EN = 1'b1;
        expect_word(we, 16'hFFFF);
        push(we);
        wait_lane(4'd3);
        RD_EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", 64'({dout_valid, dout}), {27'd0, 1'b1, 4'h3, we[3*32 +: 32]});
        end
        drain_timed("drain_e_cycles", 13);

        // Push arriving on the cycle the last word pops goes out with no bubble
        expect_word(wf, 16'hFFFF);
        push(wf);
        wait_lane(4'd15);
        expect_word(wg, 16'hFFFF);
        push(wg);
        drain_timed("drain_g_bypass_cycles", 16);

        // Overflow: third push into a full buffer is dropped
        RD_EN = 1'b0;
        expect_word(w1, 16'hFFFF);
        push(w1);
        expect_word(w2, 16'hFFFF);
        push(w2);
        check("full_after_w2", 64'(full), 64'd1);
        push(w3);
`ifdef OUTPUT_FIFO_OVF_CNT_EN
        check("ovf_after_w3", 64'(ovf_cnt), 64'd1);
`else
        check("ovf_after_w3", 64'(ovf_cnt), 64'd0);
`endif
        drain_timed("drain_w12_cycles", 32);
        check("empty_after_w12", 64'(empty), 64'd1);

        // Asynchronous reset mid-word
        reg_write(2'd0, 16'h0FFF);
        RD_EN = 1'b1;
        expect_word(wh, 16'h0FFF);
        push(wh);
        wait_lane(4'd7);
        RD_EN = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(dout_valid), 64'd0);
        check("mid_rst_empty", 64'(empty), 64'd1);
        check("mid_rst_mask", 64'(lane_mask), 64'hFFFF);
        check("mid_rst_dout", 64'(dout), 64'd0);
        check("mid_rst_ovf", 64'(ovf_cnt), 64'd0);
        q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        RD_EN = 1'b1;
        expect_word(wi, 16'hFFFF);
        push(wi);
        tick();
        check("post_rst_first", 64'(dout), {28'd0, 4'h0, wi[31:0]});
        drain_timed("drain_i_cycles", 16);
        tick();
        check("final_empty", 64'(empty), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
